// File: rtl/sign_extend_rs_rt_pkg.sv
// Shared widths, the immediate type and the sign-extension rule used by
// decode-stage immediate generators.
package sign_extend_rs_rt_pkg;

    localparam int unsigned FIELD_W = 6;
    localparam int unsigned IMM_W   = 12;
    localparam int unsigned XLEN    = 32;

    typedef logic [IMM_W-1:0] imm12_t;

    // The sign bit is always the msb of the concatenated immediate.
    function automatic logic [XLEN-1:0] sext_imm12(input imm12_t imm);
        return {{(XLEN - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/sign_extend_rs_rt_dffr.sv
// 32-bit register with synchronous, active-high reset to zero.
module sign_extend_rs_rt_dffr
    import sign_extend_rs_rt_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    logic [XLEN-1:0] q_d;
    logic [XLEN-1:0] q_q;

    // Next state: reset takes priority over the new data.
    always_comb begin
        q_d = d;
        if (rst) begin
            q_d = '0;
        end
    end

    // State update on every rising edge; no enable.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sign_extend_rs_rt.sv
// Immediate generator: {rs, rt} as a 12-bit signed value, sign-extended
// to 32 bits, with a combinational result and a registered copy.
module sign_extend_rs_rt
    import sign_extend_rs_rt_pkg::*;
(
    input  logic [FIELD_W-1:0] rs,
    input  logic [FIELD_W-1:0] rt,
    output logic [XLEN-1:0]    out,
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    out_q
);

    imm12_t imm12;

    // Pure combinational extension; no clock or reset involvement.
    always_comb begin
        imm12 = {rs, rt};
        out   = sext_imm12(imm12);
    end

    sign_extend_rs_rt_dffr u_out_reg (
        .clk (clk),
        .rst (rst),
        .d   (out),
        .q   (out_q)
    );

endmodule

// File: tb/tb_sign_extend_rs_rt.sv
// Bench for sign_extend_rs_rt: directed and random inputs, a numeric
// reference model, and a queue-based scoreboard for the registered output.
module tb_sign_extend_rs_rt;

    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [31:0] out;
    logic        clk;
    logic        rst;
    logic [31:0] out_q;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    bit driver_done = 0;

    sign_extend_rs_rt dut (
        .rs    (rs),
        .rt    (rt),
        .out   (out),
        .clk   (clk),
        .rst   (rst),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value of the 12-bit two's-complement number rs*64+rt.
    function automatic logic [31:0] model(input int unsigned a, input int unsigned b);
        int v;
        v = int'(a) * 64 + int'(b);
        if (v >= 2048) v = v - 4096;
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Hold inputs for n cycles; each cycle queues the out_q expected after the next edge.
    task automatic apply(input int unsigned a, input int unsigned b, input bit r,
                         input int n, input string name);
        logic [31:0] e;
        e = model(a, b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rs  = 6'(a);
            rt  = 6'(b);
            rst = r;
            exp_q.push_back(r ? 32'h0 : e);
            #1;
            check({name, "_out"}, out, e);
        end
    endtask

    // Monitor: compares out_q after every rising edge against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_q", out_q, e);
            end
        end
    end

    initial begin
        rs  = '0;
        rt  = '0;
        rst = 1'b1;
        apply(0, 0, 1, 2, "reset");
        apply(0, 0, 0, 5, "zero");
        apply(63, 63, 0, 5, "minus1");
        apply(0, 63, 0, 5, "pos3f");
        apply(63, 0, 0, 5, "neg64");
        apply(31, 63, 0, 5, "max");
        apply(32, 0, 0, 5, "min");
        // Reset mid-stream for one edge, then release with inputs held.
        apply(63, 63, 0, 2, "pre_rst");
        apply(63, 63, 1, 1, "in_rst");
        apply(63, 63, 0, 2, "post_rst");
        // Reset and a new input on the same edge: reset wins.
        apply(5, 9, 1, 1, "rst_new");
        apply(5, 9, 0, 1, "after_rst");
        for (int k = 0; k < 300; k++) begin
            apply($urandom_range(0, 63), $urandom_range(0, 63), ($urandom_range(0, 15) == 0),
                  1, "rand");
        end
        @(negedge clk);
        @(negedge clk);
        driver_done = 1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
